// File: rtl/rv_regfile_mp_pkg.sv
// Shared constants and types for the multi-port RV32I/RV32E register file.
// The address helper is common to the write port, the read ports and the scoreboard.
package rv_regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREGS_I  = 32;
    localparam int unsigned NREGS_E  = 16;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [4:0]          reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xlen_t;

    // x0 and addresses beyond the architectural count never hold state.
    function automatic bit addr_valid(int unsigned addr, int unsigned nregs);
        return (addr != REG_ZERO) && (addr < nregs);
    endfunction

endpackage

// File: rtl/rv_regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file: write port, packed read
// ports with busy flags, and the issue port that marks destinations pending.
interface rv_regfile_mp_if
    import rv_regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned AW     = 5,
    parameter int unsigned NUM_RD = 2
);

    logic                   write_enable;
    logic [AW-1:0]          write_addr;
    logic [XLEN-1:0]        write_data;
    logic [NUM_RD*AW-1:0]   read_addr;
    logic [NUM_RD*XLEN-1:0] read_data;
    logic [NUM_RD-1:0]      read_busy;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic                   busy_any;

    modport master (
        output write_enable, write_addr, write_data, read_addr, issue_valid, issue_rd,
        input  read_data, read_busy, busy_any
    );

    modport slave (
        input  write_enable, write_addr, write_data, read_addr, issue_valid, issue_rd,
        output read_data, read_busy, busy_any
    );

endinterface

// File: rtl/rv_regfile_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback. A new issue to the same register wins over a coincident writeback.
module rv_scoreboard
    import rv_regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_I,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_valid_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                clr_valid_i,
    input  logic [AW-1:0]       clr_addr_i,
    output logic [(1<<AW)-1:0]  pending_o,
    output logic                busy_any_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Clear first so that a simultaneous issue to the same register re-marks it.
    always_comb begin
        pending_d = pending_q;
        if (clr_valid_i && addr_valid(32'(clr_addr_i), NREGS)) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (set_valid_i && addr_valid(32'(set_addr_i), NREGS)) begin
            pending_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o  = pending_q;
    assign busy_any_o = |pending_q;

endmodule

// File: rtl/rv_regfile_mp.sv
// Parametrised integer register file: NUM_RD combinational read ports, one
// synchronous write port, optional write-to-read bypass and hazard scoreboard.
module rv_regfile_mp
    import rv_regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_I,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned NUM_RD = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    rv_regfile_mp_if.slave  bus_if
);

    // Storage covers the full address space; entries at or above NREGS are never written.
    localparam int unsigned DEPTH = 1 << AW;

    logic [XLEN-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             busyAny;
    logic             wrValid;

    assign wrValid = bus_if.write_enable && addr_valid(32'(bus_if.write_addr), NREGS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrValid) begin
            regs_q[bus_if.write_addr] <= bus_if.write_data;
        end
    end

    rv_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_valid_i (bus_if.issue_valid),
        .set_addr_i  (bus_if.issue_rd),
        .clr_valid_i (bus_if.write_enable),
        .clr_addr_i  (bus_if.write_addr),
        .pending_o   (pending),
        .busy_any_o  (busyAny)
    );

    logic [XLEN-1:0] rdData [NUM_RD];
    logic            rdBusy [NUM_RD];

    // rst_n gates the ports so a bypassed write cannot leak out while reset is held.
    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          rdValid;
        logic          fwd;

        assign ra        = bus_if.read_addr[g*AW +: AW];
        assign rdValid   = rst_n && addr_valid(32'(ra), NREGS);
        assign fwd       = BYPASS && wrValid && (bus_if.write_addr == ra);
        assign rdData[g] = !rdValid ? '0 : (fwd ? bus_if.write_data : regs_q[ra]);
        assign rdBusy[g] = rdValid && pending[ra] && !fwd;
    end

    always_comb begin
        bus_if.read_data = '0;
        bus_if.read_busy = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            bus_if.read_data[i*XLEN +: XLEN] = rdData[i];
            bus_if.read_busy[i]              = rdBusy[i];
        end
    end

    assign bus_if.busy_any = busyAny;

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Self-checking bench for rv_regfile_mp: bypass and non-bypass RV32I instances
// share one stimulus stream; a third instance exercises the RV32E configuration.
module tb_rv_regfile_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rv_regfile_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2)) ifA ();
    rv_regfile_mp_if #(.XLEN(32), .AW(5), .NUM_RD(2)) ifB ();
    rv_regfile_mp_if #(.XLEN(32), .AW(5), .NUM_RD(3)) ifE ();

    assign ifB.write_enable = ifA.write_enable;
    assign ifB.write_addr   = ifA.write_addr;
    assign ifB.write_data   = ifA.write_data;
    assign ifB.read_addr    = ifA.read_addr;
    assign ifB.issue_valid  = ifA.issue_valid;
    assign ifB.issue_rd     = ifA.issue_rd;

    rv_regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .BYPASS(1'b1))
        dutA (.clk(clk), .rst_n(rst_n), .bus_if(ifA));
    rv_regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NUM_RD(2), .BYPASS(1'b0))
        dutB (.clk(clk), .rst_n(rst_n), .bus_if(ifB));
    rv_regfile_mp #(.XLEN(32), .NREGS(16), .AW(5), .NUM_RD(3), .BYPASS(1'b1))
        dutE (.clk(clk), .rst_n(rst_n), .bus_if(ifE));

    // Architectural state of the RV32I instances (identical for A and B).
    logic [31:0] mRegs [32];
    bit          mPend [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [1:0]  busyA;
        logic [1:0]  busyB;
        logic        any;
    } vec_t;

    vec_t tbl [18];

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(logic we, logic [4:0] wa, logic [31:0] wd,
                                 logic iv, logic [4:0] ird, logic [4:0] r0, logic [4:0] r1);
        ifA.write_enable = we;
        ifA.write_addr   = wa;
        ifA.write_data   = wd;
        ifA.issue_valid  = iv;
        ifA.issue_rd     = ird;
        ifA.read_addr    = {r1, r0};
    endtask

    task automatic applyE(logic we, logic [4:0] wa, logic [31:0] wd, logic iv,
                          logic [4:0] ird, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2);
        ifE.write_enable = we;
        ifE.write_addr   = wa;
        ifE.write_data   = wd;
        ifE.issue_valid  = iv;
        ifE.issue_rd     = ird;
        ifE.read_addr    = {r2, r1, r0};
    endtask

    function automatic logic [31:0] refRead(bit bp, logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (bp && ifA.write_enable && ifA.write_addr == a) return ifA.write_data;
        return mRegs[a];
    endfunction

    function automatic logic refBusy(bit bp, logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (bp && ifA.write_enable && ifA.write_addr == a) return 1'b0;
        return mPend[a];
    endfunction

    function automatic logic refAny();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r = r | mPend[i];
        return r;
    endfunction

    task automatic modelEdge();
        if (ifA.write_enable && ifA.write_addr != 5'd0) begin
            mRegs[ifA.write_addr] = ifA.write_data;
            mPend[ifA.write_addr] = 1'b0;
        end
        if (ifA.issue_valid && ifA.issue_rd != 5'd0) mPend[ifA.issue_rd] = 1'b1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = 32'h0;
            mPend[i] = 1'b0;
        end
    endtask

    task automatic checkModel(string tag);
        logic [63:0] dA;
        logic [63:0] dB;
        logic [9:0]  ra;
        dA = ifA.read_data;
        dB = ifB.read_data;
        ra = ifA.read_addr;
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("%s_A_data%0d", tag, p), dA[p*32 +: 32], refRead(1'b1, ra[p*5 +: 5]));
            checkOutput($sformatf("%s_B_data%0d", tag, p), dB[p*32 +: 32], refRead(1'b0, ra[p*5 +: 5]));
            checkOutput($sformatf("%s_A_busy%0d", tag, p), 32'(ifA.read_busy[p]), 32'(refBusy(1'b1, ra[p*5 +: 5])));
            checkOutput($sformatf("%s_B_busy%0d", tag, p), 32'(ifB.read_busy[p]), 32'(refBusy(1'b0, ra[p*5 +: 5])));
        end
        checkOutput($sformatf("%s_A_any", tag), 32'(ifA.busy_any), 32'(refAny()));
        checkOutput($sformatf("%s_B_any", tag), 32'(ifB.busy_any), 32'(refAny()));
    endtask

    initial begin
        logic [63:0] dA;
        logic [63:0] dB;
        logic [95:0] dE;
        logic [4:0]  wa;
        logic [4:0]  r0;
        logic [4:0]  r1;

        //              we wa  wd             iv ird r0 r1  a0            a1            b0            b1            bA     bB     any
        tbl[0]  = '{1'b1, 5'd1, 32'h000000FF, 1'b0, 5'd0, 5'd1, 5'd2, 32'h000000FF, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 5'd2, 32'h000000BB, 1'b0, 5'd0, 5'd1, 5'd2, 32'h000000FF, 32'h000000BB, 32'h000000FF, 32'h0,        2'b00, 2'b00, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd1, 5'd2, 32'h000000FF, 32'h000000BB, 32'h000000FF, 32'h000000BB, 2'b00, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd1, 32'h0,        32'h000000FF, 32'h0,        32'h000000FF, 2'b00, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00, 2'b00, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd1, 32'hDEADBEEF, 32'h000000FF, 32'hDEADBEEF, 32'h000000FF, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b01, 2'b01, 1'b1};
        tbl[9]  = '{1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 5'd7, 5'd1, 32'h00000077, 32'h000000FF, 32'h0,        32'h000000FF, 2'b00, 2'b01, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd1, 32'h00000077, 32'h000000FF, 32'h00000077, 32'h000000FF, 2'b00, 2'b00, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h00000077, 32'h00000077, 32'h00000077, 32'h00000077, 2'b00, 2'b00, 1'b0};
        tbl[12] = '{1'b1, 5'd7, 32'h00000099, 1'b1, 5'd7, 5'd7, 5'd0, 32'h00000099, 32'h0,        32'h00000077, 32'h0,        2'b00, 2'b01, 1'b1};
        tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h00000099, 32'h0,        32'h00000099, 32'h0,        2'b01, 2'b01, 1'b1};
        tbl[14] = '{1'b1, 5'd7, 32'h000000AA, 1'b1, 5'd3, 5'd7, 5'd3, 32'h000000AA, 32'h0,        32'h00000099, 32'h0,        2'b00, 2'b01, 1'b1};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd3, 32'h000000AA, 32'h0,        32'h000000AA, 32'h0,        2'b10, 2'b10, 1'b1};
        tbl[16] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'h0,        2'b00, 2'b11, 1'b1};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd7, 32'hA5A5A5A5, 32'h000000AA, 32'hA5A5A5A5, 32'h000000AA, 2'b00, 2'b00, 1'b0};

        modelClear();
        applyE(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        // A write with a matching read while reset is held must not be forwarded.
        applyStimulus(1'b1, 5'd1, 32'hFFFFFFFF, 1'b1, 5'd1, 5'd1, 5'd1);
        #12;
        dA = ifA.read_data;
        checkOutput("rsthold_A_data0", dA[31:0], 32'h0);
        checkOutput("rsthold_A_busy", 32'(ifA.read_busy), 32'h0);
        checkOutput("rsthold_A_any", 32'(ifA.busy_any), 32'h0);

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a));
            #1;
            dA = ifA.read_data;
            dB = ifB.read_data;
            checkOutput($sformatf("rst_x%0d_A", a), dA[31:0] | dA[63:32], 32'h0);
            checkOutput($sformatf("rst_x%0d_B", a), dB[31:0] | dB[63:32], 32'h0);
            checkOutput($sformatf("rst_x%0d_busy", a), 32'({ifA.read_busy, ifB.read_busy}), 32'h0);
            checkOutput($sformatf("rst_x%0d_any", a), 32'({ifA.busy_any, ifB.busy_any}), 32'h0);
        end
        @(posedge clk);
        #1;

        for (int v = 0; v < 18; v++) begin
            applyStimulus(tbl[v].we, tbl[v].wa, tbl[v].wd, tbl[v].iv, tbl[v].ird, tbl[v].r0, tbl[v].r1);
            @(negedge clk);
            dA = ifA.read_data;
            dB = ifB.read_data;
            checkOutput($sformatf("vec%0d_A0", v), dA[31:0], tbl[v].a0);
            checkOutput($sformatf("vec%0d_A1", v), dA[63:32], tbl[v].a1);
            checkOutput($sformatf("vec%0d_B0", v), dB[31:0], tbl[v].b0);
            checkOutput($sformatf("vec%0d_B1", v), dB[63:32], tbl[v].b1);
            checkOutput($sformatf("vec%0d_busyA", v), 32'(ifA.read_busy), 32'(tbl[v].busyA));
            checkOutput($sformatf("vec%0d_busyB", v), 32'(ifB.read_busy), 32'(tbl[v].busyB));
            checkOutput($sformatf("vec%0d_anyA", v), 32'(ifA.busy_any), 32'(tbl[v].any));
            checkOutput($sformatf("vec%0d_anyB", v), 32'(ifB.busy_any), 32'(tbl[v].any));
            @(posedge clk);
            modelEdge();
            #1;
        end

        for (int c = 0; c < 400; c++) begin
            wa = 5'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            applyStimulus(1'($urandom_range(0, 1)), wa, $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), r0, r1);
            @(negedge clk);
            checkModel($sformatf("rnd%0d", c));
            @(posedge clk);
            modelEdge();
            #1;
        end

        // Async reset between edges, with a write to x3 in flight.
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 5'd3, 5'd3);
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 5'd3, 5'd3);
        #2;
        dB = ifB.read_data;
        checkOutput("arst_pre_B_data", dB[31:0], 32'hA5A5A5A5);
        checkOutput("arst_pre_B_busy", 32'(ifB.read_busy), 32'h3);
        rst_n = 1'b0;
        #1;
        dA = ifA.read_data;
        dB = ifB.read_data;
        checkOutput("arst_A_data", dA[31:0] | dA[63:32], 32'h0);
        checkOutput("arst_B_data", dB[31:0] | dB[63:32], 32'h0);
        checkOutput("arst_busy", 32'({ifA.read_busy, ifB.read_busy}), 32'h0);
        checkOutput("arst_any", 32'({ifA.busy_any, ifB.busy_any}), 32'h0);
        @(posedge clk);
        #1;
        dA = ifA.read_data;
        checkOutput("arst_edge_A_data", dA[31:0], 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
        @(negedge clk);
        rst_n = 1'b1;
        modelClear();
        @(posedge clk);
        #1;
        checkModel("arst_after");

        // RV32E: addresses 16..31 are outside the file.
        applyE(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 5'd4, 5'd4, 5'd4);
        #1;
        dE = ifE.read_data;
        checkOutput("e_byp_p0", dE[31:0], 32'h4);
        checkOutput("e_byp_p2", dE[95:64], 32'h4);
        @(posedge clk);
        #1;
        applyE(1'b1, 5'd20, 32'h0000DEAD, 1'b1, 5'd20, 5'd20, 5'd4, 5'd0);
        #1;
        dE = ifE.read_data;
        checkOutput("e_oor_byp_p0", dE[31:0], 32'h0);
        checkOutput("e_oor_p1", dE[63:32], 32'h4);
        @(posedge clk);
        #1;
        applyE(1'b1, 5'd16, 32'h00001616, 1'b1, 5'd15, 5'd20, 5'd16, 5'd15);
        @(posedge clk);
        #1;
        applyE(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd20, 5'd16, 5'd15);
        #1;
        dE = ifE.read_data;
        checkOutput("e_rd20", dE[31:0], 32'h0);
        checkOutput("e_rd16", dE[63:32], 32'h0);
        checkOutput("e_rd15", dE[95:64], 32'h0);
        checkOutput("e_busy", 32'(ifE.read_busy), 32'h4);
        checkOutput("e_any", 32'(ifE.busy_any), 32'h1);
        applyE(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4, 5'd4);
        #1;
        dE = ifE.read_data;
        checkOutput("e_x4_p0", dE[31:0], 32'h4);
        checkOutput("e_x4_p1", dE[63:32], 32'h4);
        checkOutput("e_x4_p2", dE[95:64], 32'h4);
        checkOutput("e_x4_busy", 32'(ifE.read_busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
- Parametrised RV32I/RV32E integer register file with NUM_RD read ports and a single synchronous write port.
- Adds asynchronous-low reset, optional write-to-read bypass and a per-register pending-write scoreboard for hazard detection.
- Sits between decode (read and issue side) and writeback.
- x0 is hardwired to zero and is never marked pending.

Parameters:
- XLEN, 32: data width in bits.
- NREGS, 32: architectural register count; 16 selects RV32E.
- AW, $clog2(NREGS): register address width.
- NUM_RD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the reads; 0 = reads return the old value.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- write_enable  in  1  commit write_data to write_addr at the clk edge.
- write_addr  in  AW  destination register of the write.
- write_data  in  XLEN  data to write.
- read_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- read_data  out  NUM_RD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- read_busy  out  NUM_RD  bit i = register at read_addr port i has a pending write.
- issue_valid  in  1  an instruction with destination issue_rd is issued this cycle.
- issue_rd  in  AW  destination register to mark pending.
- busy_any  out  1  OR of all pending bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers are cleared to 0; all pending bits are cleared.
  - read_data = 0 and read_busy = 0 while reset is held.
  - busy_any = 0.
  - Release of reset is synchronised externally; the block samples inputs from the first rising edge after rst_n goes high.
- Write:
  - At posedge, if write_enable=1 and write_addr!=0, then regs[write_addr] <= write_data.
  - Writes to x0 are silently discarded.
  - write_addr >= NREGS is ignored with no state change; this matters when NREGS is not a power of two.
- Read (combinational, zero latency):
  - read_addr=0 returns 0.
  - Out-of-range addresses return 0.
  - Otherwise the port returns regs[read_addr].
  - With BYPASS=1: if write_enable=1, write_addr==read_addr and the address is non-zero, the port returns write_data in the same cycle.
  - With BYPASS=0: the port returns the old value until the following cycle.
- Scoreboard: one pending bit per register, bit 0 tied to 0.
  - Set at posedge when issue_valid=1 and issue_rd!=0.
  - Cleared at posedge when write_enable=1 and write_addr!=0.
  - Simultaneous set and clear of the same register: set wins, because a new producer was issued.
  - Set and clear of different registers in the same cycle: both take effect.
  - Setting an already-pending register leaves it at 1; no counting.
  - read_busy[i] = pending[read_addr_i] & ~(BYPASS & write_enable & write_addr==read_addr_i).
  - Consequence: with BYPASS=1, a register being written this cycle reports not busy on a matching read port.
- All read ports are fully independent and may alias each other or write_addr.
- Reset asserted mid-write: the write is lost; state is all-zero after reset.

Decomposition:
- Package rv_regfile_pkg holds:
  - XLEN_DEF = 32, NREGS_I = 32, NREGS_E = 16.
  - REG_ZERO = 0.
  - Typedef reg_addr_t (5 bits) and xlen_t.
- One sub-module: rv_scoreboard.
  - Owns the NREGS pending bits, set/clear priority and busy_any.
  - Instantiated once.
- Read-port muxes are a generate loop over NUM_RD.

Test Plan:
1. Reset: hold rst_n=0, then release. Read addresses 1..31 on every port -> read_data=0, read_busy=0, busy_any=0.
2. Write and read:
   - Write x1=32'hFF, x2=32'hBB on consecutive edges.
   - Next cycle, port0=1, port1=2 -> 32'hFF, 32'hBB.
   - Write x0=32'h1234, then read x0 -> 0.
3. Bypass:
   - With BYPASS=1, write x5=32'hDEADBEEF and read port0=5 in the same cycle -> 32'hDEADBEEF before the edge.
   - With BYPASS=0, same stimulus -> old value 0 before the edge, 32'hDEADBEEF after it.
4. Scoreboard:
   - issue_rd=7 -> next cycle read_busy=1 on a port reading 7, busy_any=1.
   - write_addr=7 -> busy clears after the edge; it reads 0 in the same cycle if BYPASS=1.
   - Same-cycle issue_rd=7 and write_addr=7 -> x7 remains pending.
5. Async reset mid-operation:
   - With x3=32'hA5A5A5A5 and x3 pending, pulse rst_n low between clock edges.
   - -> read_data and busy go to 0 immediately, without waiting for a clock edge.
6. RV32E configuration (NREGS=16, NUM_RD=3):
   - Write write_addr=20 -> ignored.
   - Read address 20 -> 0.
   - All three ports reading x4 after writing 32'h4 -> all return 32'h4.
